// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : local instruction store with a small prefetch queue.
// Rev 1.0
// ============================================================================
module instr_fetch_unit #(
   parameter int IMEM_DEPTH = 16,
   parameter int QDEPTH     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_en,
   input  logic [3:0]  load_addr,
   input  logic [31:0] load_data,
   input  logic        start,
   input  logic [7:0]  start_pc,
   input  logic        redirect_valid,
   input  logic [7:0]  redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [7:0]  instr_pc,
   output logic        busy,
   output logic        done
);
   localparam int         C_AW    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int         C_CW    = $clog2(QDEPTH + 1);
   localparam logic [8:0] C_DEPTH = 9'(IMEM_DEPTH);
   localparam logic [C_CW:0] C_QD = (C_CW + 1)'(QDEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [7:0]        pc_q, pc_d;
   logic [C_CW-1:0]   count_q, count_d;
   logic              inflight_q, inflight_d;
   logic [7:0]        infl_pc_q, infl_pc_d;
   logic [31:0]       q_instr_q [QDEPTH];
   logic [31:0]       q_instr_d [QDEPTH];
   logic [7:0]        q_pc_q [QDEPTH];
   logic [7:0]        q_pc_d [QDEPTH];

   logic [31:0]       mem [IMEM_DEPTH];
   logic [31:0]       rdata_q;

   logic              pop;
   logic              restart;
   logic              issue;
   logic              pc_in_range;
   logic [7:0]        new_pc;
   logic [C_CW-1:0]   base;
   logic [C_CW:0]     occ;

   // Store is not reset; the read register only captures on an issued read.
   always_ff @(posedge clk) begin
      if (load_en && ({5'b0, load_addr} < C_DEPTH)) begin
         mem[C_AW'(load_addr)] <= load_data;
      end
      if (issue) begin
         rdata_q <= mem[pc_q[C_AW-1:0]];
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inflight_d  = 1'b0;
      infl_pc_d   = infl_pc_q;
      q_instr_d   = q_instr_q;
      q_pc_d      = q_pc_q;
      issue       = 1'b0;
      pop         = (count_q != '0) & instr_ready;
      restart     = redirect_valid | start;
      new_pc      = redirect_valid ? redirect_pc : start_pc;
      pc_in_range = ({1'b0, pc_q} < C_DEPTH);
      base        = count_q - C_CW'(pop);
      occ         = {1'b0, base} + (C_CW + 1)'(inflight_q);

      if (pop) begin
         for (int i = 0; i < QDEPTH - 1; i++) begin
            q_instr_d[i] = q_instr_q[i + 1];
            q_pc_d[i]    = q_pc_q[i + 1];
         end
      end
      // Returning read lands behind whatever survives this cycle's pop.
      if (inflight_q) begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (C_CW'(i) == base) begin
               q_instr_d[i] = rdata_q;
               q_pc_d[i]    = infl_pc_q;
            end
         end
      end
      count_d = base + C_CW'(inflight_q);

      case (state_q)
         IDLE, HALT: begin
            if (restart) begin
               state_d = FETCH;
               pc_d    = new_pc;
               count_d = '0;
            end
         end
         FETCH: begin
            if (restart) begin
               pc_d    = new_pc;
               count_d = '0;
            end else if (pc_in_range && (occ < C_QD)) begin
               issue      = 1'b1;
               pc_d       = pc_q + 8'd1;
               inflight_d = 1'b1;
               infl_pc_d  = pc_q;
            end else if (!pc_in_range && !inflight_q && (count_q == '0)) begin
               state_d = HALT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
         infl_pc_q  <= '0;
         q_instr_q  <= '{default: '0};
         q_pc_q     <= '{default: '0};
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         infl_pc_q  <= infl_pc_d;
         q_instr_q  <= q_instr_d;
         q_pc_q     <= q_pc_d;
      end
   end

   assign instr_valid = (count_q != '0);
   assign instr       = q_instr_q[0];
   assign instr_pc    = q_pc_q[0];
   assign busy        = (state_q == FETCH);
   assign done        = (state_q == HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_unit : directed stimulus with a delivery-order scoreboard.
// Rev 1.0
// ============================================================================
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_en = 1'b0;
   logic [3:0]  load_addr = '0;
   logic [31:0] load_data = '0;
   logic        start = 1'b0;
   logic [7:0]  start_pc = '0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] img [16];
   logic [7:0]  exp_pc = '0;
   logic        armed = 1'b0;
   logic        hold = 1'b0;
   logic [7:0]  hold_pc = '0;
   logic [31:0] hold_instr = '0;
   logic        flush_next = 1'b0;

   instr_fetch_unit #(.IMEM_DEPTH(16), .QDEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .start          (start),
      .start_pc       (start_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int max_cyc);
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clk);
         if (done) break;
      end
      check("wait_done", 32'(done), 32'd1);
      check("halt_busy", 32'(busy), 32'd0);
      tick();
   endtask

   // Scoreboard: every delivered word must be the next pc of the current
   // stream with the store's contents; redirects restart the stream.
   always @(negedge clk) begin
      if (!rst_n) begin
         armed      = 1'b0;
         hold       = 1'b0;
         flush_next = 1'b0;
         check("rst_valid", 32'(instr_valid), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(done), 32'd0);
      end else begin
         if (!armed || flush_next) check("sb_idle_valid", 32'(instr_valid), 32'd0);
         flush_next = 1'b0;
         if (hold) begin
            check("sb_hold_valid", 32'(instr_valid), 32'd1);
            check("sb_hold_pc", 32'(instr_pc), 32'(hold_pc));
            check("sb_hold_instr", instr, hold_instr);
         end
         if (busy && done) check("sb_busy_done", 32'(busy & done), 32'd0);
         if (instr_valid) begin
            check("sb_pc", 32'(instr_pc), 32'(exp_pc));
            if (exp_pc < 8'd16) check("sb_instr", instr, img[exp_pc[3:0]]);
            if (instr_ready) exp_pc = exp_pc + 8'd1;
         end
         hold       = instr_valid && !instr_ready && !redirect_valid && !start;
         hold_pc    = instr_pc;
         hold_instr = instr;
         if (redirect_valid || start) begin
            exp_pc     = redirect_valid ? redirect_pc : start_pc;
            armed      = 1'b1;
            flush_next = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] pcs2 [4];
      pcs2 = '{8'd12, 8'd13, 8'd14, 8'd15};
      for (int i = 0; i < 16; i++) img[i] = 32'h1000_0000 + 32'(i);

      #1;
      check("por_valid", 32'(instr_valid), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;

      // Idle after reset: nothing moves without start.
      for (int c = 0; c < 10; c++) begin
         tick();
         @(negedge clk);
         check("idle_valid", 32'(instr_valid), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_done", 32'(done), 32'd0);
      end
      tick();

      for (int i = 0; i < 16; i++) begin
         load_en   = 1'b1;
         load_addr = 4'(i);
         load_data = img[i];
         tick();
      end
      load_en = 1'b0;

      // Stream the tail of the store: pcs 12..15 back to back, two cycles in.
      instr_ready = 1'b1;
      start       = 1'b1;
      start_pc    = 8'd12;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) check("t2_busy", 32'(busy), 32'd1);
         check("t2_valid", 32'(instr_valid), (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
         if (c >= 3 && c <= 6) begin
            check("t2_pc", 32'(instr_pc), 32'(pcs2[c - 3]));
            check("t2_instr", instr, 32'h1000_0000 + 32'(pcs2[c - 3]));
         end
         tick();
      end
      wait_done(5);

      // Backpressure: head pc 0 held, then delivery resumes in order.
      instr_ready = 1'b0;
      start       = 1'b1;
      start_pc    = 8'd0;
      tick();
      start = 1'b0;
      repeat (2) tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("t3_hold_valid", 32'(instr_valid), 32'd1);
         check("t3_hold_pc", 32'(instr_pc), 32'd0);
         tick();
      end
      instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t3_valid", 32'(instr_valid), 32'd1);
         check("t3_pc", 32'(instr_pc), 32'(k));
         tick();
      end
      wait_done(30);

      // Redirect while pc 5 is at the head.
      start    = 1'b1;
      start_pc = 8'd0;
      tick();
      start = 1'b0;
      repeat (7) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 8'd11;
      @(negedge clk);
      check("t4_head_pc", 32'(instr_pc), 32'd5);
      check("t4_head_valid", 32'(instr_valid), 32'd1);
      tick();
      redirect_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check("t4_valid", 32'(instr_valid), (c >= 3) ? 32'd1 : 32'd0);
         if (c >= 3) check("t4_pc", 32'(instr_pc), 32'd8 + 32'(c));
         tick();
      end
      wait_done(20);

      // Out-of-range start: no fetch, HALT on the second cycle.
      start    = 1'b1;
      start_pc = 8'd20;
      tick();
      start = 1'b0;
      @(negedge clk);
      check("t5_c1_done", 32'(done), 32'd0);
      check("t5_c1_busy", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      check("t5_c2_done", 32'(done), 32'd1);
      check("t5_c2_valid", 32'(instr_valid), 32'd0);
      repeat (3) tick();

      // Reset with two queued entries, then restart at pc 3.
      instr_ready = 1'b0;
      start       = 1'b1;
      start_pc    = 8'd0;
      tick();
      start = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("t6_pre_valid", 32'(instr_valid), 32'd1);
      check("t6_pre_pc", 32'(instr_pc), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(instr_valid), 32'd0);
      check("t6_rst_instr", instr, 32'd0);
      check("t6_rst_pc", 32'(instr_pc), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_done", 32'(done), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("t6_post_valid", 32'(instr_valid), 32'd0);
         check("t6_post_busy", 32'(busy), 32'd0);
         tick();
      end
      instr_ready = 1'b1;
      start       = 1'b1;
      start_pc    = 8'd3;
      tick();
      start = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      check("t6_first_valid", 32'(instr_valid), 32'd1);
      check("t6_first_pc", 32'(instr_pc), 32'd3);
      check("t6_first_instr", instr, 32'h1000_0003);
      repeat (2) tick();

      // start and redirect together: redirect wins.
      start          = 1'b1;
      start_pc       = 8'd2;
      redirect_valid = 1'b1;
      redirect_pc    = 8'd9;
      tick();
      start          = 1'b0;
      redirect_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check("t7_valid", 32'(instr_valid), (c == 3) ? 32'd1 : 32'd0);
         if (c == 3) check("t7_pc", 32'(instr_pc), 32'd9);
         tick();
      end
      wait_done(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
